// File: rtl/id_ex_pipe_reg_pkg.sv
// id_ex_pipe_reg_pkg
// Shared field widths and control-bundle layout for the ID stage and the ID/EX register, so the
// hazard zeroing mux in ID and this register agree on what each control bit means.
// Contents:
//   - default widths for operands, register addresses, ALUOp and the performance counters
//   - ctrl_w(): width of the packed control bundle (six single-bit controls plus ALUOp)
//   - bit offsets of the single-bit controls above the ALUOp field
//   - encodings of the deferred-flush flag
package id_ex_pipe_reg_pkg;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned REG_AW_DEF  = 5;
  localparam int unsigned ALUOP_W_DEF = 2;
  localparam int unsigned CNT_W_DEF   = 16;

  // Number of single-bit control signals carried alongside ALUOp.
  localparam int unsigned CTRL_BITS = 6;

  // Single-bit control positions, counted from the top of the ALUOp field.
  // Bundle layout (MSB..LSB): RegDst, ALUSrc, RegWrite, MemToReg, MemRead, MemWrite, ALUOp.
  localparam int unsigned OFS_REGDST   = 5;
  localparam int unsigned OFS_ALUSRC   = 4;
  localparam int unsigned OFS_REGWRITE = 3;
  localparam int unsigned OFS_MEMTOREG = 2;
  localparam int unsigned OFS_MEMREAD  = 1;
  localparam int unsigned OFS_MEMWRITE = 0;

  // Deferred-flush flag states.
  localparam logic PEND_IDLE = 1'b0;
  localparam logic PEND_SET  = 1'b1;

  function automatic int unsigned ctrl_w(input int unsigned aluop_w);
    return CTRL_BITS + aluop_w;
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg_sat_counter.sv
// sat_counter
// Saturating up-counter for performance debug. Counts edges with inc_i high and sticks at the
// all-ones value instead of wrapping.
// Ports:
//   clk_i    in   1      clock
//   rst_n_i  in   1      asynchronous active-low clear
//   inc_i    in   1      increment request for this edge
//   count_o  out  CNT_W  current count
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_d;
  logic             w_at_max;

  always_comb begin
    w_at_max  = (r_count == {CNT_W{1'b1}});
    w_count_d = r_count;
    if (inc_i && !w_at_max) begin
      w_count_d = r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_d;
    end
  end

  assign count_o = r_count;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg
// ID/EX pipeline register. Captures the (possibly hazard-zeroed) control bits and ID operands each
// cycle and presents them to EX, with stall hold, flush-to-bubble (deferred while stalled), a
// per-stage valid bit and saturating bubble/stall counters.
// Ports:
//   clk_i, rst_n_i                       clock, asynchronous active-low reset
//   start_i                              CPU run enable; 0 loads bubbles
//   Stall_i                              memory stall; freezes the register
//   Flush_i                              branch/jump flush; next load is a bubble
//   RegDst_i..MemWrite_i, ALUOp_i        control from the ID zeroing mux
//   RSdata_i, RTdata_i, Imm_i            operands and sign-extended immediate
//   RSaddr_i, RTaddr_i, RDaddr_i         register addresses
//   RegDst_o..RDaddr_o                   registered copies for EX (MemRead_o/RTaddr_o also feed
//                                        the load-use detector)
//   Valid_o                              1 = real instruction in EX, 0 = bubble
//   BubbleCnt_o, StallCnt_o              saturating performance counters
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned REG_AW  = REG_AW_DEF,
  parameter int unsigned ALUOP_W = ALUOP_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic               Stall_i,
  input  logic               Flush_i,
  input  logic               RegDst_i,
  input  logic               ALUSrc_i,
  input  logic               RegWrite_i,
  input  logic               MemToReg_i,
  input  logic               MemRead_i,
  input  logic               MemWrite_i,
  input  logic [ALUOP_W-1:0] ALUOp_i,
  input  logic [DATA_W-1:0]  RSdata_i,
  input  logic [DATA_W-1:0]  RTdata_i,
  input  logic [DATA_W-1:0]  Imm_i,
  input  logic [REG_AW-1:0]  RSaddr_i,
  input  logic [REG_AW-1:0]  RTaddr_i,
  input  logic [REG_AW-1:0]  RDaddr_i,
  output logic               RegDst_o,
  output logic               ALUSrc_o,
  output logic               RegWrite_o,
  output logic               MemToReg_o,
  output logic               MemRead_o,
  output logic               MemWrite_o,
  output logic [ALUOP_W-1:0] ALUOp_o,
  output logic [DATA_W-1:0]  RSdata_o,
  output logic [DATA_W-1:0]  RTdata_o,
  output logic [DATA_W-1:0]  Imm_o,
  output logic [REG_AW-1:0]  RSaddr_o,
  output logic [REG_AW-1:0]  RTaddr_o,
  output logic [REG_AW-1:0]  RDaddr_o,
  output logic               Valid_o,
  output logic [CNT_W-1:0]   BubbleCnt_o,
  output logic [CNT_W-1:0]   StallCnt_o
);

  localparam int unsigned CTRL_W = ctrl_w(ALUOP_W);

  logic [CTRL_W-1:0] w_ctrl_in;
  logic [CTRL_W-1:0] w_ctrl_d;
  logic              w_valid_d;
  logic              w_load_bubble;
  logic              w_hold;
  logic              w_pend_d;

  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [REG_AW-1:0] r_rs_addr;
  logic [REG_AW-1:0] r_rt_addr;
  logic [REG_AW-1:0] r_rd_addr;
  logic              r_valid;
  logic              r_pend;

  assign w_ctrl_in = {RegDst_i, ALUSrc_i, RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i, ALUOp_i};

  // Decision for this edge. start_i=0 outranks a stall, so a stopped CPU keeps loading bubbles
  // even with Stall_i high. A flush seen during a stall is remembered in r_pend and paid out on
  // the first unstalled edge.
  always_comb begin
    w_hold        = start_i && Stall_i;
    w_load_bubble = !start_i || (!Stall_i && (Flush_i || (r_pend == PEND_SET)));
    w_ctrl_d      = w_load_bubble ? '0 : w_ctrl_in;
    w_valid_d     = !w_load_bubble;
  end

  always_comb begin
    w_pend_d = r_pend;
    if (!start_i) begin
      w_pend_d = PEND_IDLE;
    end else if (Stall_i) begin
      if (Flush_i) begin
        w_pend_d = PEND_SET;
      end
    end else begin
      w_pend_d = PEND_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pend <= PEND_IDLE;
    end else begin
      r_pend <= w_pend_d;
    end
  end

  // Data/address fields load alongside a bubble too; only the controls and valid are forced.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ctrl    <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_rs_addr <= '0;
      r_rt_addr <= '0;
      r_rd_addr <= '0;
      r_valid   <= 1'b0;
    end else if (!w_hold) begin
      r_ctrl    <= w_ctrl_d;
      r_rs_data <= RSdata_i;
      r_rt_data <= RTdata_i;
      r_imm     <= Imm_i;
      r_rs_addr <= RSaddr_i;
      r_rt_addr <= RTaddr_i;
      r_rd_addr <= RDaddr_i;
      r_valid   <= w_valid_d;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_bubble_cnt (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .inc_i  (w_load_bubble),
    .count_o(BubbleCnt_o)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .inc_i  (w_hold),
    .count_o(StallCnt_o)
  );

  assign RegDst_o   = r_ctrl[ALUOP_W+OFS_REGDST];
  assign ALUSrc_o   = r_ctrl[ALUOP_W+OFS_ALUSRC];
  assign RegWrite_o = r_ctrl[ALUOP_W+OFS_REGWRITE];
  assign MemToReg_o = r_ctrl[ALUOP_W+OFS_MEMTOREG];
  assign MemRead_o  = r_ctrl[ALUOP_W+OFS_MEMREAD];
  assign MemWrite_o = r_ctrl[ALUOP_W+OFS_MEMWRITE];
  assign ALUOp_o    = r_ctrl[ALUOP_W-1:0];
  assign RSdata_o   = r_rs_data;
  assign RTdata_o   = r_rt_data;
  assign Imm_o      = r_imm;
  assign RSaddr_o   = r_rs_addr;
  assign RTaddr_o   = r_rt_addr;
  assign RDaddr_o   = r_rd_addr;
  assign Valid_o    = r_valid;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg
// Directed bench for id_ex_pipe_reg with CNT_W=4 so saturation is reachable quickly.
module tb_id_ex_pipe_reg;

  logic        clk_i;
  logic        rst_n_i;
  logic        start_i, Stall_i, Flush_i;
  logic        RegDst_i, ALUSrc_i, RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i;
  logic [1:0]  ALUOp_i;
  logic [31:0] RSdata_i, RTdata_i, Imm_i;
  logic [4:0]  RSaddr_i, RTaddr_i, RDaddr_i;
  logic        RegDst_o, ALUSrc_o, RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o;
  logic [1:0]  ALUOp_o;
  logic [31:0] RSdata_o, RTdata_o, Imm_o;
  logic [4:0]  RSaddr_o, RTaddr_o, RDaddr_o;
  logic        Valid_o;
  logic [3:0]  BubbleCnt_o, StallCnt_o;

  int checks = 0;
  int errors = 0;

  id_ex_pipe_reg #(
    .DATA_W (32),
    .REG_AW (5),
    .ALUOP_W(2),
    .CNT_W  (4)
  ) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .start_i    (start_i),
    .Stall_i    (Stall_i),
    .Flush_i    (Flush_i),
    .RegDst_i   (RegDst_i),
    .ALUSrc_i   (ALUSrc_i),
    .RegWrite_i (RegWrite_i),
    .MemToReg_i (MemToReg_i),
    .MemRead_i  (MemRead_i),
    .MemWrite_i (MemWrite_i),
    .ALUOp_i    (ALUOp_i),
    .RSdata_i   (RSdata_i),
    .RTdata_i   (RTdata_i),
    .Imm_i      (Imm_i),
    .RSaddr_i   (RSaddr_i),
    .RTaddr_i   (RTaddr_i),
    .RDaddr_i   (RDaddr_i),
    .RegDst_o   (RegDst_o),
    .ALUSrc_o   (ALUSrc_o),
    .RegWrite_o (RegWrite_o),
    .MemToReg_o (MemToReg_o),
    .MemRead_o  (MemRead_o),
    .MemWrite_o (MemWrite_o),
    .ALUOp_o    (ALUOp_o),
    .RSdata_o   (RSdata_o),
    .RTdata_o   (RTdata_o),
    .Imm_o      (Imm_o),
    .RSaddr_o   (RSaddr_o),
    .RTaddr_o   (RTaddr_o),
    .RDaddr_o   (RDaddr_o),
    .Valid_o    (Valid_o),
    .BubbleCnt_o(BubbleCnt_o),
    .StallCnt_o (StallCnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_ctrl();
    RegDst_i   = 1'b0;
    ALUSrc_i   = 1'b0;
    RegWrite_i = 1'b0;
    MemToReg_i = 1'b0;
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
    ALUOp_i    = 2'b00;
  endtask

  initial begin
    rst_n_i  = 1'b0;
    start_i  = 1'b0;
    Stall_i  = 1'b0;
    Flush_i  = 1'b0;
    clear_ctrl();
    RSdata_i = '0;
    RTdata_i = '0;
    Imm_i    = '0;
    RSaddr_i = '0;
    RTaddr_i = '0;
    RDaddr_i = '0;

    // Reset state
    step();
    step();
    check("rst_valid", {31'd0, Valid_o}, 32'd0);
    check("rst_regwrite", {31'd0, RegWrite_o}, 32'd0);
    check("rst_rsdata", RSdata_o, 32'd0);
    check("rst_bcnt", {28'd0, BubbleCnt_o}, 32'd0);
    check("rst_scnt", {28'd0, StallCnt_o}, 32'd0);

    // Basic load
    #2 rst_n_i = 1'b1;
    start_i    = 1'b1;
    RegWrite_i = 1'b1;
    ALUOp_i    = 2'b10;
    RSdata_i   = 32'h1234;
    RTdata_i   = 32'h5678;
    step();
    check("ld_regwrite", {31'd0, RegWrite_o}, 32'd1);
    check("ld_aluop", {30'd0, ALUOp_o}, 32'd2);
    check("ld_rsdata", RSdata_o, 32'h1234);
    check("ld_valid", {31'd0, Valid_o}, 32'd1);
    check("ld_bcnt", {28'd0, BubbleCnt_o}, 32'd0);

    // Three stalled edges with changing inputs
    Stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      RSdata_i   = 32'hA000 + i;
      RegWrite_i = 1'b0;
      ALUOp_i    = 2'b01;
      step();
      check("stall_rsdata", RSdata_o, 32'h1234);
      check("stall_regwrite", {31'd0, RegWrite_o}, 32'd1);
    end
    check("stall_aluop", {30'd0, ALUOp_o}, 32'd2);
    check("stall_scnt", {28'd0, StallCnt_o}, 32'd3);
    check("stall_bcnt", {28'd0, BubbleCnt_o}, 32'd0);

    // Normal load after stall: a load instruction
    Stall_i   = 1'b0;
    clear_ctrl();
    MemRead_i = 1'b1;
    RTaddr_i  = 5'd7;
    RSdata_i  = 32'hAAAA;
    step();
    check("ld2_memread", {31'd0, MemRead_o}, 32'd1);
    check("ld2_rtaddr", {27'd0, RTaddr_o}, 32'd7);
    check("ld2_regwrite", {31'd0, RegWrite_o}, 32'd0);
    check("ld2_valid", {31'd0, Valid_o}, 32'd1);

    // Flush on the first edge of a three-cycle stall
    Stall_i    = 1'b1;
    Flush_i    = 1'b1;
    clear_ctrl();
    MemWrite_i = 1'b1;
    RegDst_i   = 1'b1;
    step();
    check("fs_hold_memread", {31'd0, MemRead_o}, 32'd1);
    check("fs_hold_valid", {31'd0, Valid_o}, 32'd1);
    Flush_i = 1'b0;
    step();
    step();
    check("fs_hold2_memwrite", {31'd0, MemWrite_o}, 32'd0);
    check("fs_scnt", {28'd0, StallCnt_o}, 32'd6);
    check("fs_bcnt_held", {28'd0, BubbleCnt_o}, 32'd0);
    Stall_i = 1'b0;
    step();
    check("fs_bub_valid", {31'd0, Valid_o}, 32'd0);
    check("fs_bub_memwrite", {31'd0, MemWrite_o}, 32'd0);
    check("fs_bub_regdst", {31'd0, RegDst_o}, 32'd0);
    check("fs_bub_bcnt", {28'd0, BubbleCnt_o}, 32'd1);
    step();
    check("fs_after_valid", {31'd0, Valid_o}, 32'd1);
    check("fs_after_memwrite", {31'd0, MemWrite_o}, 32'd1);
    check("fs_after_bcnt", {28'd0, BubbleCnt_o}, 32'd1);

    // Repeated flush while pending yields one bubble
    Stall_i = 1'b1;
    Flush_i = 1'b1;
    step();
    step();
    Stall_i = 1'b0;
    Flush_i = 1'b0;
    step();
    check("rf_bub_valid", {31'd0, Valid_o}, 32'd0);
    check("rf_bcnt", {28'd0, BubbleCnt_o}, 32'd2);
    check("rf_scnt", {28'd0, StallCnt_o}, 32'd8);
    step();
    check("rf_after_valid", {31'd0, Valid_o}, 32'd1);
    check("rf_after_bcnt", {28'd0, BubbleCnt_o}, 32'd2);

    // Unstalled flush: controls zeroed, data still loaded
    Flush_i  = 1'b1;
    RTdata_i = 32'hDEAD;
    step();
    check("fl_memwrite", {31'd0, MemWrite_o}, 32'd0);
    check("fl_valid", {31'd0, Valid_o}, 32'd0);
    check("fl_rtdata", RTdata_o, 32'hDEAD);
    check("fl_bcnt", {28'd0, BubbleCnt_o}, 32'd3);
    Flush_i = 1'b0;
    step();
    check("fl_after_valid", {31'd0, Valid_o}, 32'd1);

    // Hazard-zeroed controls are a valid entry, not a counted bubble
    clear_ctrl();
    step();
    check("hz_valid", {31'd0, Valid_o}, 32'd1);
    check("hz_memwrite", {31'd0, MemWrite_o}, 32'd0);
    check("hz_bcnt", {28'd0, BubbleCnt_o}, 32'd3);

    // Asynchronous reset while a flush is pending
    RegWrite_i = 1'b1;
    Stall_i    = 1'b1;
    Flush_i    = 1'b1;
    step();
    check("rp_scnt", {28'd0, StallCnt_o}, 32'd9);
    check("rp_hold_valid", {31'd0, Valid_o}, 32'd1);
    #2 rst_n_i = 1'b0;
    #1;
    check("rp_async_valid", {31'd0, Valid_o}, 32'd0);
    check("rp_async_scnt", {28'd0, StallCnt_o}, 32'd0);
    check("rp_async_bcnt", {28'd0, BubbleCnt_o}, 32'd0);
    #2 rst_n_i = 1'b1;
    Stall_i = 1'b0;
    Flush_i = 1'b0;
    step();
    check("rp_load_valid", {31'd0, Valid_o}, 32'd1);
    check("rp_load_regwrite", {31'd0, RegWrite_o}, 32'd1);
    check("rp_load_bcnt", {28'd0, BubbleCnt_o}, 32'd0);

    // start_i=0 outranks stall; bubble counter saturates
    start_i = 1'b0;
    Stall_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 14) check("sat_bcnt15", {28'd0, BubbleCnt_o}, 32'd15);
    end
    check("sat_bcnt_nowrap", {28'd0, BubbleCnt_o}, 32'd15);
    check("sat_scnt", {28'd0, StallCnt_o}, 32'd0);
    check("sat_valid", {31'd0, Valid_o}, 32'd0);
    check("sat_regwrite", {31'd0, RegWrite_o}, 32'd0);
    start_i = 1'b1;
    Stall_i = 1'b0;
    step();
    check("sat_resume_valid", {31'd0, Valid_o}, 32'd1);
    check("sat_resume_bcnt", {28'd0, BubbleCnt_o}, 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
